// File: rtl/nes_bus_pkg.sv
// Shared bus definitions for the CPU/PPU memory bus: DMA state encoding,
// default register addresses and the DMA trigger decode.
package nes_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } dma_state_t;

    localparam logic [15:0] DMA_REG_DEFAULT  = 16'h4014;
    localparam logic [15:0] OAM_DATA_DEFAULT = 16'h2004;

    // A CPU write landing on the DMA register starts a sprite transfer.
    function automatic logic is_dma_trigger(
        input logic        wr,
        input logic [15:0] addr,
        input logic [15:0] reg_addr
    );
        return wr && (addr == reg_addr);
    endfunction

endpackage

// File: rtl/oam_dma_if.sv
// CPU-side and memory-side bus signals of the sprite DMA arbiter.
// master: the DMA/arbiter block; slave: the CPU core plus shared memory.
interface oam_dma_if;
    logic [15:0] cpu_addr;
    logic [7:0]  cpu_d_out;
    logic        cpu_write;
    logic        cpu_ready;
    logic [7:0]  cpu_d_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_d_out;
    logic        mem_write;
    logic [7:0]  mem_d_in;
    logic        busy;

    modport master (
        input  cpu_addr, cpu_d_out, cpu_write, mem_d_in,
        output cpu_ready, cpu_d_in, mem_addr, mem_d_out, mem_write, busy
    );

    modport slave (
        output cpu_addr, cpu_d_out, cpu_write, mem_d_in,
        input  cpu_ready, cpu_d_in, mem_addr, mem_d_out, mem_write, busy
    );
endinterface

// File: rtl/oam_dma.sv
// Sprite DMA controller and bus arbiter. A CPU write to DMA_REG stalls the
// CPU and copies page XX00-XXFF to OAM_DATA with alternating read/write cycles.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | CPU owns the bus, watching for a DMA register write
// HALT  | CPU stalled; waits for in-flight CPU writes to drain
// ALIGN | one spare cycle so every READ lands on an even cycle
// READ  | DMA reads {page, idx}, latches the byte
// WRITE | DMA writes the latched byte to OAM_DATA, advances idx
module oam_dma
    import nes_bus_pkg::*;
#(
    parameter logic [15:0] DMA_REG  = DMA_REG_DEFAULT,
    parameter logic [15:0] OAM_DATA = OAM_DATA_DEFAULT
) (
    input  logic      clk,
    input  logic      reset,
    oam_dma_if.master bus
);

    dma_state_t state;
    dma_state_t state_nxt;
    logic [7:0] page;
    logic [7:0] idx;
    logic [7:0] data;
    logic       odd;
    logic       trigger;

    assign trigger = is_dma_trigger(bus.cpu_write, bus.cpu_addr, DMA_REG);

    // State register, cycle parity, source page, byte index and read latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            page  <= 8'h00;
            idx   <= 8'h00;
            data  <= 8'h00;
            odd   <= 1'b0;
        end else begin
            state <= state_nxt;
            odd   <= ~odd;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page <= bus.cpu_d_out;
                        idx  <= 8'h00;
                    end
                end
                READ:  data <= bus.mem_d_in;
                WRITE: begin
                    // idx stops at FF; the terminal compare ends the copy
                    if (idx != 8'hFF) begin
                        idx <= idx + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Next-state decode and the bus mux (CPU pass-through unless DMA owns it).
    always_comb begin
        state_nxt     = state;
        bus.mem_addr  = bus.cpu_addr;
        bus.mem_d_out = bus.cpu_d_out;
        bus.mem_write = bus.cpu_write;
        case (state)
            IDLE: begin
                if (trigger) begin
                    state_nxt = HALT;
                end
            end
            HALT: begin
                if (!bus.cpu_write) begin
                    state_nxt = odd ? READ : ALIGN;
                end
            end
            ALIGN: state_nxt = READ;
            READ: begin
                bus.mem_addr  = {page, idx};
                bus.mem_write = 1'b0;
                state_nxt     = WRITE;
            end
            WRITE: begin
                bus.mem_addr  = OAM_DATA;
                bus.mem_d_out = data;
                bus.mem_write = 1'b1;
                state_nxt     = (idx == 8'hFF) ? IDLE : READ;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.cpu_ready = (state == IDLE);
    assign bus.busy      = (state != IDLE);
    assign bus.cpu_d_in  = bus.mem_d_in;

endmodule
